// File: rtl/axi_sitcp_pkg.sv
// Shared definitions for the SiTCP AXI4-Lite path: response codes and
// register-bank address decode helpers.
package axi_sitcp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Which part of the register map a word index falls into.
  typedef enum logic [1:0] {
    REGION_CTRL = 2'd0,
    REGION_STAT = 2'd1,
    REGION_NONE = 2'd2
  } region_e;

  // Word index from a byte address; the two lane bits are dropped because
  // byte lanes are selected by wstrb alone.
  function automatic int unsigned word_index(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

  // Unsigned range decode: ctrl words first, status words after them.
  function automatic region_e decode_region(input int unsigned idx,
                                            input int unsigned num_ctrl,
                                            input int unsigned num_stat);
    if (idx < num_ctrl) begin
      return REGION_CTRL;
    end else if (idx < num_ctrl + num_stat) begin
      return REGION_STAT;
    end else begin
      return REGION_NONE;
    end
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank_if.sv
// AXI4-Lite bus bundle between the RBCP bridge (master) and the register bank (slave).
interface axi_lite_reg_bank_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_wr_hold.sv
// Single-entry holding register for one AXI write channel (AW or W).
// Ready is registered: it reflects "empty and write path not blocked" as of
// the next cycle, so it never depends combinationally on valid.
module axi_lite_wr_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             allow_i,   // next-cycle permission to accept (low while a response is pending)
  input  logic             clr_i,     // entry consumed by a commit
  output logic             ready_o,
  output logic             held_o,
  output logic [WIDTH-1:0] data_o
);

  logic             held_q, held_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Capture on handshake, release on commit, and precompute next ready.
  always_comb begin
    held_d = held_q;
    data_d = data_q;
    if (clr_i) begin
      held_d = 1'b0;
    end else if (valid_i && ready_q) begin
      held_d = 1'b1;
      data_d = data_i;
    end
    ready_d = !held_d && allow_i;
  end

  // Entry state; reset discards anything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      held_q  <= held_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = ready_q;
  assign held_o  = held_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: NUM_CTRL byte-writable control words driven
// to fabric with per-word commit strobes, followed by NUM_STAT read-only
// status words sampled from fabric.
module axi_lite_reg_bank
  import axi_sitcp_pkg::*;
#(
  parameter int NUM_CTRL   = 8,
  parameter int NUM_STAT   = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_lite_reg_bank_if.slave    s_axi,
  output logic [NUM_CTRL*32-1:0] ctrl_out,
  output logic [NUM_CTRL-1:0]    ctrl_wr_pulse,
  input  logic [NUM_STAT*32-1:0] stat_in
);

  // ---------------------------------------------------------------- write path
  logic                  aw_held, w_held;
  logic                  aw_ready, w_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [35:0]           w_payload;
  logic                  commit;
  logic                  allow_wr;

  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic [NUM_CTRL-1:0][31:0]     ctrl_q, ctrl_d;
  logic [NUM_CTRL-1:0]           pulse_q, pulse_d;

  int unsigned aw_idx;
  region_e     aw_region;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;

  axi_lite_wr_hold #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (s_axi.awvalid),
    .data_i  (s_axi.awaddr),
    .allow_i (allow_wr),
    .clr_i   (commit),
    .ready_o (aw_ready),
    .held_o  (aw_held),
    .data_o  (aw_addr)
  );

  axi_lite_wr_hold #(.WIDTH(36)) u_w_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (s_axi.wvalid),
    .data_i  ({s_axi.wstrb, s_axi.wdata}),
    .allow_i (allow_wr),
    .clr_i   (commit),
    .ready_o (w_ready),
    .held_o  (w_held),
    .data_o  (w_payload)
  );

  assign commit    = aw_held && w_held && !bvalid_q;
  assign aw_idx    = word_index(32'(aw_addr));
  assign aw_region = decode_region(aw_idx, NUM_CTRL, NUM_STAT);
  assign wr_strb   = w_payload[35:32];
  assign wr_data   = w_payload[31:0];
  // Both channels stay closed for as long as a write response is outstanding.
  assign allow_wr  = !bvalid_d;

  // Commit merges enabled lanes into the hit word and raises the response.
  always_comb begin
    ctrl_d   = ctrl_q;
    pulse_d  = '0;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;
    if (bvalid_q && s_axi.bready) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = (aw_region == REGION_CTRL) ? RESP_OKAY : RESP_SLVERR;
      if (aw_region == REGION_CTRL) begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (aw_idx == i) begin
            pulse_d[i] = 1'b1;
            for (int k = 0; k < 4; k++) begin
              if (wr_strb[k]) begin
                ctrl_d[i][8*k +: 8] = wr_data[8*k +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Write-side state: control array, commit strobes, response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      pulse_q  <= '0;
      bresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      pulse_q  <= pulse_d;
      bresp_q  <= bresp_d;
      bvalid_q <= bvalid_d;
    end
  end

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign ctrl_out      = ctrl_q;
  assign ctrl_wr_pulse = pulse_q;

  // ----------------------------------------------------------------- read path
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ar_hs;
  int unsigned ar_idx;
  region_e     ar_region;
  logic [31:0] rd_word;

  assign ar_hs     = s_axi.arvalid && arready_q;
  assign ar_idx    = word_index(32'(s_axi.araddr));
  assign ar_region = decode_region(ar_idx, NUM_CTRL, NUM_STAT);

  // Read mux; uses the pre-edge ctrl value so a same-cycle commit is not visible.
  always_comb begin
    rd_word = '0;
    if (ar_region == REGION_CTRL) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (ar_idx == i) begin
          rd_word = ctrl_q[i];
        end
      end
    end else if (ar_region == REGION_STAT) begin
      for (int j = 0; j < NUM_STAT; j++) begin
        if (ar_idx == NUM_CTRL + j) begin
          rd_word = stat_in[32*j +: 32];
        end
      end
    end
  end

  // Single outstanding read: capture on AR handshake, hold until rready.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axi.rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = (ar_region == REGION_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
    arready_d = !rvalid_d;
  end

  // Read-side state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  // Protection bits and address lane bits carry no meaning for this bank.
  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, aw_addr[1:0], s_axi.araddr[1:0]};

endmodule
